// File: rtl/arb_pkg.sv
// arb_pkg: shared owner tag, access-size codes and default depth for sram_like_arbiter
package arb_pkg;
    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam int MAX_OUTST_DEF = 2;
endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// owner_fifo: in-order tag FIFO recording which requester owns each outstanding transaction
// Ports: clk, reset (sync, active-high); push/push_tag write the tail; pop drops the head;
// head_tag, count, full, empty report state. Pointers wrap modulo DEPTH.
module owner_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_tag,
    output logic [W-1:0]  head_tag,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] tags [DEPTH];
    logic [PW-1:0] head, tail;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_tag = tags[head];

    always_ff @(posedge clk)
        if (do_push) tags[tail] <= push_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= nxt(tail);
            if (do_pop) head <= nxt(head);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like memory port between inst fetch and data access
// Ports: clk, reset (sync, active-high); inst_* read-only fetch port; data_* load/store port;
// mem_* shared memory port. Responses return in order and are routed by an owner FIFO.
// Optional ARB_RR_EN: round-robin on ties instead of fixed data-over-inst priority.
module sram_like_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF,
    parameter int OWN_W = 1,
    localparam int CW = $clog2(MAX_OUTST + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    owner_t own, tie_own, lock_own;
    logic locked, is_d, accept, resp, full, empty;
    logic [OWN_W-1:0] head_tag;
    logic [CW-1:0] count;

`ifdef ARB_RR_EN
    owner_t last;
    assign tie_own = (last == OWN_DATA) ? OWN_INST : OWN_DATA;
    always_ff @(posedge clk) begin
        if (reset) last <= OWN_DATA;
        else if (accept) last <= own;
    end
`else
    assign tie_own = OWN_DATA;
`endif

    // a request stalled by mem_addr_ok keeps its owner until accepted
    always_comb begin
        own = locked ? lock_own :
              (inst_req & data_req) ? tie_own :
              data_req ? OWN_DATA : OWN_INST;
        is_d = own == OWN_DATA;
    end

    assign mem_req   = (inst_req | data_req) & ~full & ~reset;
    assign mem_wr    = ~reset & is_d & data_wr;
    assign mem_size  = reset ? 2'd0 : is_d ? data_size : SZ_WORD;
    assign mem_wstrb = (~reset & is_d) ? data_wstrb : 4'd0;
    assign mem_wdata = (~reset & is_d) ? data_wdata : 32'd0;
    assign mem_addr  = reset ? 32'd0 : is_d ? data_addr : inst_addr;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~is_d;
    assign data_addr_ok = accept & is_d;

    // a response with nothing outstanding is dropped
    assign resp         = mem_data_ok & ~empty & ~reset;
    assign inst_data_ok = resp & (head_tag != OWN_W'(OWN_DATA));
    assign data_data_ok = resp & (head_tag == OWN_W'(OWN_DATA));
    assign inst_rdata   = reset ? 32'd0 : mem_rdata;
    assign data_rdata   = reset ? 32'd0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            locked   <= 1'b0;
            lock_own <= OWN_INST;
        end else if (mem_req & ~mem_addr_ok) begin
            locked   <= 1'b1;
            lock_own <= own;
        end else if (mem_addr_ok) begin
            locked   <= 1'b0;
        end
    end

    owner_fifo #(.DEPTH(MAX_OUTST), .W(OWN_W)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .pop      (resp),
        .push_tag (OWN_W'(own)),
        .head_tag (head_tag),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assert property (@(posedge clk) disable iff (reset) mem_data_ok |-> !empty);
    assert property (@(posedge clk) disable iff (reset) accept |-> (count < CW'(MAX_OUTST)));
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed stimulus with a response scoreboard for sram_like_arbiter
module tb_sram_like_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;

    int passed = 0;
    int total = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    sram_like_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic rd(input logic [31:0] a);
        data_req = 1; data_wr = 0; data_size = 2'd2; data_wstrb = 0; data_addr = a; data_wdata = 0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_data_ok = 1; mem_rdata = d;
    endtask

    task automatic expect_resp(input logic is_data, input logic [31:0] d);
        exp_q.push_back({is_data, d});
    endtask

    // {is_data, rdata}: which port must see data_ok and the data it must carry
    always @(negedge clk) begin
        if (!reset && (inst_data_ok || data_data_ok)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("resp_port", {30'd0, inst_data_ok, data_data_ok}, e[32] ? 32'd1 : 32'd2);
                check("resp_rdata", e[32] ? data_rdata : inst_rdata, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1;
        inst_req = 1; inst_addr = 32'h1c000000; data_req = 1; data_addr = 32'h1000;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hffffffff;
        #2;
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata", inst_rdata | data_rdata, 0);
        tick();
        reset = 0; idle();

        // lone fetch
        tick();
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1; #1;
        check("fetch_mem_req", {31'd0, mem_req}, 1);
        check("fetch_mem_addr", mem_addr, 32'h1c000000);
        check("fetch_mem_size", {30'd0, mem_size}, 2);
        check("fetch_mem_wr", {31'd0, mem_wr}, 0);
        check("fetch_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        expect_resp(0, 32'h02800c04);
        tick(); idle(); #1;
        check("fetch_idle_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        tick(); respond(32'h02800c04);
        tick(); idle();

        // simultaneous requests: data wins, inst follows
        tick();
        inst_req = 1; inst_addr = 32'h1c000004;
        data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = 32'h1000; data_wdata = 32'hdeadbeef; mem_addr_ok = 1; #1;
        check("prio_mem_wr", {31'd0, mem_wr}, 1);
        check("prio_mem_addr", mem_addr, 32'h1000);
        check("prio_mem_wdata", mem_wdata, 32'hdeadbeef);
        check("prio_mem_wstrb", {28'd0, mem_wstrb}, 32'hf);
        check("prio_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        expect_resp(1, 32'h0);
        tick();
        data_req = 0; #1;
        check("prio_inst_addr", mem_addr, 32'h1c000004);
        check("prio_inst_ok", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        check("prio_inst_forced", {mem_wr, mem_size, mem_wstrb, 25'd0} | mem_wdata,
              {1'b0, 2'd2, 4'd0, 25'd0});
        expect_resp(0, 32'haaaa0001);
        tick(); idle(); respond(32'h0);
        tick(); respond(32'haaaa0001);
        tick(); idle();

        // lock: inst stalled three cycles, data arrives meanwhile
        tick();
        inst_req = 1; inst_addr = 32'h1c000008; #1;
        check("lock_req", {31'd0, mem_req}, 1);
        check("lock_c0_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        for (int i = 1; i < 3; i++) begin
            tick();
            rd(32'h2000); #1;
            check("lock_addr", mem_addr, 32'h1c000008);
            check("lock_data_ok_low", {31'd0, data_addr_ok}, 0);
        end
        tick();
        mem_addr_ok = 1; #1;
        check("lock_release_addr", mem_addr, 32'h1c000008);
        check("lock_release_ok", {30'd0, inst_addr_ok, data_addr_ok}, 2);
        expect_resp(0, 32'h33330000);
        tick();
        inst_req = 0; #1;
        check("lock_then_data", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        check("lock_then_addr", mem_addr, 32'h2000);
        expect_resp(1, 32'h44440000);
        tick(); idle(); respond(32'h33330000);
        tick(); respond(32'h44440000);
        tick(); idle();

        // full FIFO, no bypass on pop
        tick(); rd(32'h3000); mem_addr_ok = 1; expect_resp(1, 32'h55555555);
        tick(); rd(32'h3004); #1;
        check("full_second_ok", {31'd0, data_addr_ok}, 1);
        expect_resp(1, 32'h66666666);
        tick(); rd(32'h3008); inst_req = 1; inst_addr = 32'h1c00000c; #1;
        check("full_mem_req", {31'd0, mem_req}, 0);
        check("full_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        tick(); respond(32'h55555555); #1;
        check("full_pop_no_bypass", {31'd0, mem_req}, 0);
        tick(); mem_data_ok = 0; #1;
        check("full_reenable", {31'd0, mem_req}, 1);
        check("full_third_ok", {30'd0, inst_addr_ok, data_addr_ok}, 1);
        expect_resp(1, 32'h77777777);
        tick(); idle(); respond(32'h66666666);
        tick(); respond(32'h77777777);
        tick(); idle();

        // ordering
        tick(); inst_req = 1; inst_addr = 32'h1c000010; mem_addr_ok = 1; expect_resp(0, 32'h11111111);
        tick(); inst_req = 0; rd(32'h5000); expect_resp(1, 32'h22222222);
        tick(); idle(); respond(32'h11111111);
        tick(); respond(32'h22222222);
        tick(); idle();

        // reset mid-transaction
        tick(); inst_req = 1; inst_addr = 32'h1c000020; mem_addr_ok = 1;
        tick();
        reset = 1; mem_data_ok = 1; mem_rdata = 32'h12345678; #1;
        check("midrst_outputs", {26'd0, mem_req, inst_addr_ok, data_addr_ok,
              inst_data_ok, data_data_ok, mem_wr}, 0);
        check("midrst_buses", mem_addr | inst_rdata | data_rdata, 0);
        tick(); reset = 0; idle();
        tick(); inst_req = 1; inst_addr = 32'h1c000024; mem_addr_ok = 1; expect_resp(0, 32'h88888888);
        tick(); inst_addr = 32'h1c000028; #1;
        check("midrst_count_cleared", {31'd0, inst_addr_ok}, 1);
        expect_resp(0, 32'h99999999);
        tick(); idle(); respond(32'h88888888);
        tick(); respond(32'h99999999);
        tick(); idle();

        // ties right after reset: round-robin or fixed priority
        reset = 1;
        tick(); reset = 0;
        for (int i = 0; i < 3; i++) begin
            logic want_data;
`ifdef ARB_RR_EN
            want_data = (i == 1);
`else
            want_data = 1'b1;
`endif
            tick();
            idle();
            inst_req = 1; inst_addr = 32'h1c0000f0; rd(32'h4000); mem_addr_ok = 1;
            if (i > 0) respond(32'hb0000000 + i - 1);
            #1;
            check("tie_grant", {30'd0, inst_addr_ok, data_addr_ok}, want_data ? 32'd1 : 32'd2);
            expect_resp(want_data, 32'hb0000000 + i);
        end
        tick(); idle(); respond(32'hb0000002);
        tick(); idle();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
